// File: rtl/fpa_zp_reader.sv
// Reading-end sequencer for the F-PA ZP bus: steps the word select through the
// requested T words (and optionally the flags word) and hands each captured word out.
module fpa_zp_reader (
   input  logic        clk_sys,
   input  logic        clr,
   input  logic        start,
   input  logic [1:0]  len,
   input  logic        with_flags,
   input  logic        abort,
   input  logic [15:0] zp,
   output logic        zpa,
   output logic        zpb,
   output logic        _0_zp,
   output logic        busy,
   output logic [15:0] dout,
   output logic        dvalid,
   input  logic        dready,
   output logic        done,
   output logic [1:0]  dbg_state
);

   // Handshake: dout is offered while dvalid=1 and is consumed at a rising edge
   // where dvalid & dready; dvalid and dout stay put until that edge.
   typedef enum logic [1:0] {S_IDLE, S_SEL, S_HOLD, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  len_q, len_d;
   logic        flg_q, flg_d;
   logic [15:0] dout_q, dout_d;
   logic        zp_off_q, zp_off_d;
   logic        busy_q, busy_d;
   logic        dvalid_q, dvalid_d;
   logic        done_q, done_d;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      flg_d   = flg_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               len_d = len;
               cnt_d = 2'd0;
               if (len != 2'd0) begin
                  state_d = S_SEL;
                  sel_d   = 2'd0;
                  flg_d   = with_flags;
               end else if (with_flags) begin
                  // Flags-only request: emit the flags word straight away.
                  state_d = S_SEL;
                  sel_d   = 2'd3;
                  flg_d   = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SEL: begin
            dout_d  = zp;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (dvalid_q && dready) begin
               if (({1'b0, cnt_q} + 3'd1) < {1'b0, len_q}) begin
                  cnt_d   = cnt_q + 2'd1;
                  sel_d   = cnt_q + 2'd1;
                  state_d = S_SEL;
               end else if (flg_q) begin
                  flg_d   = 1'b0;
                  sel_d   = 2'd3;
                  state_d = S_SEL;
               end else begin
                  sel_d   = 2'd0;
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            sel_d   = 2'd0;
            state_d = S_IDLE;
         end
      endcase
      if (abort) begin
         state_d = S_IDLE;
         sel_d   = 2'd0;
         cnt_d   = 2'd0;
         flg_d   = 1'b0;
      end
      zp_off_d = !((state_d == S_SEL) || (state_d == S_HOLD));
      busy_d   = (state_d != S_IDLE);
      dvalid_d = (state_d == S_HOLD);
      done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk_sys or posedge clr) begin
      if (clr) begin
         state_q  <= S_IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= 2'd0;
         len_q    <= 2'd0;
         flg_q    <= 1'b0;
         dout_q   <= 16'h0000;
         zp_off_q <= 1'b1;
         busy_q   <= 1'b0;
         dvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         flg_q    <= flg_d;
         dout_q   <= dout_d;
         zp_off_q <= zp_off_d;
         busy_q   <= busy_d;
         dvalid_q <= dvalid_d;
         done_q   <= done_d;
      end
   end

   assign zpa       = sel_q[0];
   assign zpb       = sel_q[1];
   assign _0_zp     = zp_off_q;
   assign busy      = busy_q;
   assign dout      = dout_q;
   assign dvalid    = dvalid_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fpa_zp_reader.sv
// Bench for fpa_zp_reader: a behavioural F-PA ZP bus, a table of unload requests
// with hand-computed word sequences, and directed reset/abort sequences.
module tb_fpa_zp_reader;

   logic        clk_sys = 1'b0;
   logic        clr, start, with_flags, abort, dready;
   logic [1:0]  len;
   logic [15:0] zp;
   logic        zpa, zpb, zp_off, busy, dvalid, done;
   logic [15:0] dout;
   logic [1:0]  dbg_state;

   fpa_zp_reader dut (
      .clk_sys(clk_sys), .clr(clr), .start(start), .len(len),
      .with_flags(with_flags), .abort(abort), .zp(zp), .zpa(zpa), .zpb(zpb),
      ._0_zp(zp_off), .busy(busy), .dout(dout), .dvalid(dvalid),
      .dready(dready), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk_sys = ~clk_sys;

   // F-PA side: T=0x123456789A, D[0:7]=0xBC, flags Z=1 C=1 (bit 0 is the MSB).
   logic [15:0] bus_w [4];
   logic [15:0] zp_noise;
   assign zp = zp_off ? 16'h0000 : (bus_w[{zpb, zpa}] ^ zp_noise);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   typedef struct {
      logic [1:0]       len;
      logic             wf;
      int               stall;
      int               n;
      logic [3:0][15:0] w;
      logic [3:0][1:0]  s;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v, input string tag);
      int t;
      start = 1'b1; len = v.len; with_flags = v.wf; dready = (v.stall == 0);
      step();
      t = 1;
      // Later len/with_flags must be ignored; start held high while busy too.
      len = 2'($urandom_range(0, 3));
      with_flags = 1'($urandom_range(0, 1));
      if (v.n == 0) begin
         start = 1'b0;
         chk(tag, "empty_done", done, 1'b1);
         chk(tag, "empty_busy", busy, 1'b1);
         chk(tag, "empty_dvalid", dvalid, 1'b0);
         chk(tag, "empty_zpoff", zp_off, 1'b1);
         step();
         chk(tag, "empty_done_end", done, 1'b0);
         chk(tag, "empty_busy_end", busy, 1'b0);
         chk(tag, "empty_dvalid_end", dvalid, 1'b0);
         return;
      end
      chk(tag, "sel0_dvalid", dvalid, 1'b0);
      chk(tag, "sel0_zpoff", zp_off, 1'b0);
      chk(tag, "sel0_busy", busy, 1'b1);
      chk(tag, "sel0_sel", {zpb, zpa}, v.s[0]);
      for (int k = 0; k < v.n; k++) begin
         while (!dvalid && t < 40) begin
            step();
            t++;
         end
         chk(tag, $sformatf("w%0d_edge", k), t, 2 + 2 * k + ((k > 0) ? v.stall : 0));
         chk(tag, $sformatf("w%0d_dout", k), dout, v.w[k]);
         chk(tag, $sformatf("w%0d_sel", k), {zpb, zpa}, v.s[k]);
         chk(tag, $sformatf("w%0d_zpoff", k), zp_off, 1'b0);
         if (k == 0 && v.stall > 0) begin
            for (int i = 0; i < v.stall; i++) begin
               zp_noise = 16'($urandom_range(1, 65535));
               step();
               t++;
               chk(tag, "stall_dout", dout, v.w[0]);
               chk(tag, "stall_sel", {zpb, zpa}, v.s[0]);
               chk(tag, "stall_dvalid", dvalid, 1'b1);
            end
            zp_noise = 16'h0000;
            dready = 1'b1;
         end
         if (k == v.n - 1) start = 1'b0;
         step();
         t++;
         if (k < v.n - 1) begin
            chk(tag, "acc_dvalid", dvalid, 1'b0);
            chk(tag, "acc_sel", {zpb, zpa}, v.s[k + 1]);
            chk(tag, "acc_zpoff", zp_off, 1'b0);
            chk(tag, "acc_done", done, 1'b0);
         end else begin
            chk(tag, "last_done", done, 1'b1);
            chk(tag, "last_dvalid", dvalid, 1'b0);
            chk(tag, "last_zpoff", zp_off, 1'b1);
            chk(tag, "last_sel", {zpb, zpa}, 2'd0);
            chk(tag, "last_busy", busy, 1'b1);
         end
      end
      step();
      chk(tag, "end_done", done, 1'b0);
      chk(tag, "end_busy", busy, 1'b0);
   endtask

   // Brings the DUT to HOLD of word 1 of a len=3 unload with dready low.
   task automatic reach_hold_w1(input string tag);
      start = 1'b1; len = 2'd3; with_flags = 1'b0; dready = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      dready = 1'b0;
      step();
      chk(tag, "h1_dvalid", dvalid, 1'b1);
      chk(tag, "h1_sel", {zpb, zpa}, 2'd1);
      chk(tag, "h1_dout", dout, 16'h5678);
   endtask

   initial begin
      vec_t one;
      bus_w[0] = 16'h1234; bus_w[1] = 16'h5678; bus_w[2] = 16'h9ABC; bus_w[3] = 16'h9000;
      zp_noise = 16'h0000;
      clr = 1'b1; start = 1'b0; len = 2'd0; with_flags = 1'b0; abort = 1'b0; dready = 1'b0;

      vecs[0] = '{len: 2'd3, wf: 1'b1, stall: 0, n: 4,
                  w: {16'h9000, 16'h9ABC, 16'h5678, 16'h1234}, s: {2'd3, 2'd2, 2'd1, 2'd0}};
      vecs[1] = '{len: 2'd2, wf: 1'b0, stall: 5, n: 2,
                  w: {16'h0000, 16'h0000, 16'h5678, 16'h1234}, s: {2'd0, 2'd0, 2'd1, 2'd0}};
      vecs[2] = '{len: 2'd0, wf: 1'b1, stall: 0, n: 1,
                  w: {16'h0000, 16'h0000, 16'h0000, 16'h9000}, s: {2'd0, 2'd0, 2'd0, 2'd3}};
      vecs[3] = '{len: 2'd1, wf: 1'b1, stall: 2, n: 2,
                  w: {16'h0000, 16'h0000, 16'h9000, 16'h1234}, s: {2'd0, 2'd0, 2'd3, 2'd0}};
      vecs[4] = '{len: 2'd0, wf: 1'b0, stall: 0, n: 0,
                  w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, s: {2'd0, 2'd0, 2'd0, 2'd0}};
      vecs[5] = '{len: 2'd3, wf: 1'b0, stall: 1, n: 3,
                  w: {16'h0000, 16'h9ABC, 16'h5678, 16'h1234}, s: {2'd0, 2'd2, 2'd1, 2'd0}};
      one     = '{len: 2'd1, wf: 1'b0, stall: 0, n: 1,
                  w: {16'h0000, 16'h0000, 16'h0000, 16'h1234}, s: {2'd0, 2'd0, 2'd0, 2'd0}};

      #12;
      chk("reset", "zpa", zpa, 1'b0);
      chk("reset", "zpb", zpb, 1'b0);
      chk("reset", "zpoff", zp_off, 1'b1);
      chk("reset", "busy", busy, 1'b0);
      chk("reset", "dout", dout, 16'h0000);
      chk("reset", "dvalid", dvalid, 1'b0);
      chk("reset", "done", done, 1'b0);
      chk("reset", "state", dbg_state, 2'd0);
      @(negedge clk_sys);
      clr = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous clear in the middle of HOLD.
      reach_hold_w1("clr");
      #2 clr = 1'b1;
      #1;
      chk("clr", "dvalid", dvalid, 1'b0);
      chk("clr", "zpoff", zp_off, 1'b1);
      chk("clr", "sel", {zpb, zpa}, 2'd0);
      chk("clr", "busy", busy, 1'b0);
      chk("clr", "dout", dout, 16'h0000);
      chk("clr", "done", done, 1'b0);
      @(negedge clk_sys);
      clr = 1'b0;
      run_vec(vecs[0], "after_clr");

      // Abort in HOLD of word 1; a following len=1 unload returns only T[0:15].
      reach_hold_w1("abort");
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort", "dvalid", dvalid, 1'b0);
      chk("abort", "busy", busy, 1'b0);
      chk("abort", "done", done, 1'b0);
      chk("abort", "zpoff", zp_off, 1'b1);
      chk("abort", "sel", {zpb, zpa}, 2'd0);
      chk("abort", "state", dbg_state, 2'd0);
      step();
      chk("abort", "done_late", done, 1'b0);
      run_vec(one, "after_abort");

      // start together with abort in IDLE is dropped.
      start = 1'b1; abort = 1'b1; len = 2'd3; with_flags = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("st_ab", "busy", busy, 1'b0);
      chk("st_ab", "zpoff", zp_off, 1'b1);
      chk("st_ab", "done", done, 1'b0);
      step();
      chk("st_ab", "busy2", busy, 1'b0);
      chk("st_ab", "dvalid2", dvalid, 1'b0);
      run_vec(vecs[1], "after_st_ab");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpa_zp_reader.md
# fpa_zp_reader

Sequencer on the reading end of the F-PA ZP bus. On command it steps the ZP word select through the requested T-register words, and optionally the flags word. It captures each word into an output register and hands the words, one per handshake, to the consumer (register-file / memory write-back path). Between transfers it holds the ZP bus forced to zero.

## Interface

Parameters:
- none.

Ports:
- clk_sys  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  begin an unload; sampled only in IDLE.
- len  in  2  number of T data words to read: 0..3.
- with_flags  in  1  append flags word (Z,M,V,C in bits 0..3) after the data words.
- abort  in  1  cancel the unload in progress; return to IDLE, no done.
- zp  in  16  ZP bus from F-PA.
- zpa  out  1  ZP select, low bit.
- zpb  out  1  ZP select, high bit.
- _0_zp  out  1  forces the ZP bus to zero; high whenever not in SEL or HOLD.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- dout  out  16  captured word.
- dvalid  out  1  dout valid; held until accepted.
- dready  in  1  consumer accepts dout when dvalid & dready at a clock edge.
- done  out  1  one-cycle pulse at end of an unload.

## Operation

- Word index i selects {zpb,zpa}:
  - 0 → T[0:15].
  - 1 → T[16:31].
  - 2 → {T[32:39], D[0:7]}.
  - Flags word → 11.
- Sequence: data words 0..len-1 in order, then the flags word if with_flags was latched.
- len and with_flags are latched when start is accepted; later changes to them are ignored.
- States and transitions:
  - IDLE: _0_zp=1, select=00.
    - start with a non-empty list → SEL, select = first word.
    - start with len=0 and with_flags=0 → DONE directly; no word is emitted.
  - SEL: _0_zp=0, select held, dvalid=0. The ZP bus settles combinationally.
    - Next edge: dout←zp, dvalid←1 → HOLD.
  - HOLD: dvalid=1, dout and select held stable.
    - On dvalid & dready: dvalid←0.
    - If words remain → SEL with the next select.
    - Otherwise → DONE, with _0_zp←1 and select←00.
  - DONE: done=1 for exactly one cycle, busy=1 → IDLE.
- A 2-bit word counter and a flags-pending bit track progress. Counter compares are against the latched len, so the counter never wraps.
- start while not in IDLE is ignored; no queuing.
- abort in any state goes to IDLE at the next edge:
  - dvalid←0, done stays 0, _0_zp←1, select←00, busy←0.
  - abort and start in the same IDLE cycle: abort wins; start is dropped.
- clr at any time, including mid-unload, forces every output to its reset value immediately.

## Timing

- Reset values:
  - zpa=0, zpb=0, _0_zp=1.
  - busy=0, dout=0, dvalid=0, done=0.
  - State IDLE, counter 0, flags-pending 0.
- start sampled at edge E0 → SEL during cycle E0..E1 → dvalid=1 and dout valid from E1, i.e. first word 2 edges after start.
- Sustained rate with dready held high: one word per 2 cycles, because each word passes through SEL.
- dready low stalls in HOLD indefinitely. dout, select and _0_zp do not change while stalled.
- done is asserted in the cycle after the final accepting edge. IDLE is reached one edge later, so a new start can be accepted 2 edges after the final accept.
- Empty request (len=0, no flags): done pulses 1 cycle after start; dvalid never rises.
- zp is registered only at the SEL→HOLD edge. Changes on zp during HOLD do not affect dout.

## Test plan

- Reset mid-HOLD, with dvalid=1 and select=01, then assert clr:
  - Immediately: dvalid=0, _0_zp=1, select 00, busy=0, dout=0.
  - After release, the next start behaves normally.
- Full unload, len=3 and with_flags=1:
  - Stimulus: zp model T=0x1234_5678_9A, D[0:7]=0xBC, flags Z=1 C=1; dready=1.
  - dout sequence: 0x1234, 0x5678, 0x9ABC, 0x9000.
  - dvalid at edges +2, +4, +6, +8 after start; done one cycle after the 4th accept.
- Backpressure, len=2 and no flags, with dready low for 5 cycles on word 0:
  - dout=T[0:15] held and select stays 00 throughout the stall.
  - Word 1 follows 2 edges after the accept.
- Empty request, len=0 and with_flags=0: done pulses at edge +1, dvalid stays 0, _0_zp stays 1.
- Abort during HOLD of word 1 of 3: IDLE at the next edge with no done. A new start with len=1 then returns T[0:15] only.
- start asserted while busy is ignored, and start with abort in the same cycle is dropped: neither changes the word sequence or the latched len.
